cosim_event_sched: RTL
======================

# cosim_event_sched

Serializes the co-simulation events a Rocket-class core produces in one cycle into a single ordered stream: instruction commit, integer writeback, long-latency writeback, FP writeback, FP load writeback and trap. The block sits between the pipeline/FPU probe points and the single-call-per-cycle DPI checker front end. It buffers bursts in a multi-push FIFO, drains one event per accepted handshake, and sequences end-of-test draining. Overflow is reported as a sticky error.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2·`NSRC`.
- `NSRC`, 6: fixed event sources; index = in-cycle order.
- `clock` in 1: sole clock.
- `reset` in 1: active-low, synchronous.
- `ev_valid` in NSRC: per-source event strobe. Bit 0 commit, 1 int wb, 2 ll wb, 3 float wb, 4 float load, 5 trap.
- `ev_addr` in NSRC×5: register index (ignored for commit and trap).
- `ev_data` in NSRC×64: wdata; commit = sign-extended PC; trap = cause.
- `ev_insn` in 32: commit instruction word (source 0 only).
- `in_ready` out 1: ≥ NSRC free entries.
- `out_valid` out 1: head event valid.
- `out_ready` in 1: consumer accepts head.
- `out_kind` out 3: source index of head.
- `out_addr` out 5, `out_data` out 64, `out_insn` out 32: head fields (insn zero unless kind 0).
- `fin_req` in 1: testbench requests finish.
- `fin_done` out 1: all events drained after `fin_req`.
- `overflow` out 1: sticky; events lost.

## Operation
- Push: each cycle, valid sources are compacted in ascending index order and written at `wptr`, `wptr+1`, … `wptr` advances by popcount(`ev_valid`), modulo DEPTH.
- Pop: when `out_valid && out_ready`, `rptr` increments.
- Push and pop may occur in the same cycle. `count_next = count + pushes − pop`, width clog2(DEPTH+1).
- `in_ready = (DEPTH − count) ≥ NSRC`, computed from registered count. It is advisory; the block never drops events while it is high.
- If pushes > DEPTH − count + pop: push nothing that cycle (all-or-nothing), set `overflow`, and enter ERR.
- FSM states:
  - RUN → DRAIN on `fin_req`.
  - DRAIN → DONE when count == 0 and no push this cycle.
  - DRAIN, DONE → ERR on overflow.
  - DONE and ERR hold until reset.
- Pushes are accepted in DRAIN. In DONE, pushes set `overflow` (late event).
- `fin_done` is high only in DONE.
- ERR keeps draining the FIFO so the checker still sees every pre-error event.
- Reset values: pointers 0, count 0, state RUN, `out_valid` 0, `fin_done` 0, `overflow` 0, `in_ready` 1.

## Timing
- Event pushed in cycle t appears at `out_*` no earlier than cycle t+1. FIFO read is registered; no input-to-output bypass.
- Head fields are stable while `out_valid && !out_ready`.
- Throughput: 1 pop/cycle. Up to NSRC pushes/cycle.
- Full: count == DEPTH → `in_ready` 0. A push in the same cycle as a pop uses the freed entry.
- Empty: `out_valid` 0, fields don't-care; a pop attempt is ignored.
- Wrap: pointer arithmetic is modulo DEPTH, including a compacted burst that straddles the end of the array.
- Reset asserted mid-burst discards all contents on the next edge. `overflow` clears.
- `fin_req` with the FIFO empty and no push: DONE two cycles later (RUN→DRAIN, DRAIN→DONE).

## Structure
- Package `cosim_pkg`:
  - `ev_kind_e`: COMMIT, INT, LL, FLOAT, FLOAD, TRAP = 0..5.
  - struct `cosim_ev_t {kind, addr, data, insn}`.
  - FSM enum `sched_state_e`.
  - `NSRC` constant.
- Sub-module `cosim_mpfifo`: parameterized N-push/1-pop circular buffer with count. Source compaction, FSM and overflow logic stay in `cosim_event_sched`.

## Test plan
- Single commit, pc 0x8000_0000, insn 0x0000_0013, `out_ready`=1 → one event, kind 0, cycle t+1; count back to 0.
- All 6 sources valid in one cycle, `out_ready`=1 → kinds 0,1,2,3,4,5 on six consecutive cycles, data intact.
- `out_ready`=0, three bursts of 6 (DEPTH 16): bursts 1–2 accepted and `in_ready` falls to 0 after them; burst 3 pushes nothing, sets `overflow`, enters ERR. Then `out_ready`=1 → exactly 12 events out.
- Wrap: advance pointers to 14, push 4 events → output order preserved across index 15→0.
- `fin_req` with 5 queued and `out_ready` toggling 1/0 → `fin_done` rises only after the 5th pop; a later push sets `overflow`.
- Assert `reset`=0 with 8 queued → next cycle `out_valid` 0, count 0, `in_ready` 1, state RUN.

Source files
------------

// File: rtl/cosim_pkg.sv
// Shared types for the co-simulation event scheduler: event record, source
// kinds and the end-of-test sequencing states.
package cosim_pkg;

   localparam int NSRC = 6;
   localparam int PCW  = $clog2(NSRC + 1);

   typedef enum logic [2:0] {
      COMMIT = 3'd0,
      INT    = 3'd1,
      LL     = 3'd2,
      FLOAT  = 3'd3,
      FLOAD  = 3'd4,
      TRAP   = 3'd5
   } ev_kind_e;

   typedef struct packed {
      ev_kind_e    kind;
      logic [4:0]  addr;
      logic [63:0] data;
      logic [31:0] insn;
   } cosim_ev_t;

   localparam int EV_W = $bits(cosim_ev_t);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERR   = 2'd3
   } sched_state_e;

   // Commit and trap carry no register index; their addr field is forced to zero.
   function automatic logic has_reg(input ev_kind_e k);
      return (k != COMMIT) && (k != TRAP);
   endfunction

endpackage

// File: rtl/cosim_mpfifo.sv
// N-push / 1-pop circular buffer. Callers guarantee push_cnt never exceeds
// the free space; status outputs are registered from the next-state count.
module cosim_mpfifo #(
   parameter int DEPTH = 16,
   parameter int NPUSH = 6,
   parameter int W     = 8
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [$clog2(NPUSH+1)-1:0]       push_cnt,
   input  logic [NPUSH-1:0][W-1:0]          push_data,
   input  logic                             pop,
   output logic [W-1:0]                     head,
   output logic                             head_valid,
   output logic [$clog2(DEPTH+1)-1:0]       count,
   output logic                             room
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(NPUSH + 1);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_next_s;
   logic          valid_r;
   logic          room_r;
   logic          pop_s;

   // Pop only when an entry exists; next count accounts for both sides.
   always_comb begin
      pop_s        = pop && valid_r;
      count_next_s = count_r + CW'(push_cnt) - CW'(pop_s);
   end

   // Storage write: the compacted burst lands at wptr, wptr+1, ... modulo DEPTH.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NPUSH; i++) begin
            if (PW'(i) < push_cnt) begin
               mem_r[AW'(wptr_r + AW'(i))] <= push_data[i];
            end
         end
      end
   end

   // Pointers, occupancy and registered status flags.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
         valid_r <= 1'b0;
         room_r  <= 1'b1;
      end else begin
         wptr_r  <= wptr_r + AW'(push_cnt);
         rptr_r  <= rptr_r + AW'(pop_s);
         count_r <= count_next_s;
         valid_r <= (count_next_s != '0);
         room_r  <= ((CW'(DEPTH) - count_next_s) >= CW'(NPUSH));
      end
   end

   assign head       = mem_r[rptr_r];
   assign head_valid = valid_r;
   assign count      = count_r;
   assign room       = room_r;

endmodule

// File: rtl/cosim_event_sched.sv
// Serializes up to NSRC same-cycle co-simulation events into one ordered
// stream, with all-or-nothing overflow detection and end-of-test draining.
module cosim_event_sched
   import cosim_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NSRC-1:0]       ev_valid,
   input  logic [NSRC-1:0][4:0]  ev_addr,
   input  logic [NSRC-1:0][63:0] ev_data,
   input  logic [31:0]           ev_insn,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2:0]            out_kind,
   output logic [4:0]            out_addr,
   output logic [63:0]           out_data,
   output logic [31:0]           out_insn,
   input  logic                  fin_req,
   output logic                  fin_done,
   output logic                  overflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int RW = CW + 1;

   logic [NSRC-1:0][EV_W-1:0] comp_s;
   cosim_ev_t                 ev_v;
   logic [PCW-1:0]            n_v;
   logic [PCW-1:0]            push_cnt_s;
   logic [PCW-1:0]            fifo_push_s;
   logic [RW-1:0]             space_s;
   logic                      pop_s;
   logic                      no_fit_s;
   logic                      accept_s;
   logic                      ovf_evt_s;
   logic [EV_W-1:0]           head_bits_s;
   cosim_ev_t                 head_s;
   logic                      head_valid_s;
   logic [CW-1:0]             count_s;
   logic                      room_s;
   sched_state_e              state_r;
   logic                      fin_done_r;
   logic                      overflow_r;

   // Compact valid sources in ascending index order into push slots.
   always_comb begin
      comp_s = '0;
      n_v    = '0;
      ev_v   = '0;
      for (int s = 0; s < NSRC; s++) begin
         ev_v.kind = ev_kind_e'(3'(s));
         ev_v.addr = ev_addr[s] & {5{has_reg(ev_v.kind)}};
         ev_v.data = ev_data[s];
         ev_v.insn = (ev_v.kind == COMMIT) ? ev_insn : 32'd0;
         if (ev_valid[s]) begin
            comp_s[n_v] = ev_v;
            n_v         = n_v + PCW'(1);
         end else begin
            n_v = n_v;
         end
      end
      push_cnt_s = n_v;
   end

   // A burst that does not fit (after this cycle's pop) is dropped whole.
   always_comb begin
      pop_s     = out_valid && out_ready;
      space_s   = RW'(DEPTH) - RW'(count_s) + RW'(pop_s);
      no_fit_s  = RW'(push_cnt_s) > space_s;
      accept_s  = 1'b0;
      ovf_evt_s = 1'b0;
      case (state_r)
         ST_RUN, ST_DRAIN: begin
            accept_s  = (push_cnt_s != '0) && !no_fit_s;
            ovf_evt_s = (push_cnt_s != '0) && no_fit_s;
         end
         ST_DONE: begin
            ovf_evt_s = (ev_valid != '0);
         end
         ST_ERR: begin
            accept_s = 1'b0;
         end
         default: begin
            accept_s = 1'b0;
         end
      endcase
      fifo_push_s = accept_s ? push_cnt_s : '0;
   end

   cosim_mpfifo #(
      .DEPTH (DEPTH),
      .NPUSH (NSRC),
      .W     (EV_W)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_cnt   (fifo_push_s),
      .push_data  (comp_s),
      .pop        (pop_s),
      .head       (head_bits_s),
      .head_valid (head_valid_s),
      .count      (count_s),
      .room       (room_s)
   );

   // End-of-test sequencing and sticky overflow; ERR keeps the FIFO draining.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r    <= ST_RUN;
         fin_done_r <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (ovf_evt_s) begin
                  state_r    <= ST_ERR;
                  overflow_r <= 1'b1;
               end else if (fin_req) begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (ovf_evt_s) begin
                  state_r    <= ST_ERR;
                  overflow_r <= 1'b1;
               end else if ((count_s == '0) && (ev_valid == '0)) begin
                  state_r    <= ST_DONE;
                  fin_done_r <= 1'b1;
               end
            end
            ST_DONE: begin
               if (ovf_evt_s) begin
                  state_r    <= ST_ERR;
                  overflow_r <= 1'b1;
                  fin_done_r <= 1'b0;
               end
            end
            ST_ERR: begin
               state_r <= ST_ERR;
            end
            default: begin
               state_r    <= ST_RUN;
               fin_done_r <= 1'b0;
            end
         endcase
      end
   end

   assign head_s    = cosim_ev_t'(head_bits_s);
   assign out_valid = head_valid_s;
   assign out_kind  = head_s.kind;
   assign out_addr  = head_s.addr;
   assign out_data  = head_s.data;
   assign out_insn  = head_s.insn;
   assign in_ready  = room_s;
   assign fin_done  = fin_done_r;
   assign overflow  = overflow_r;

endmodule
